// File: rtl/biu_pkg.sv
// Shared I2C constants: bus idle levels and default input-path tuning.
package biu_pkg;
  localparam logic SCL_IDLE = 1'b1;
  localparam logic SDA_IDLE = 1'b1;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILTER_LEN_DEF  = 3;

  // Wide enough for the largest legal FILTER_LEN (15).
  localparam int unsigned FILT_CNT_W = 4;
endpackage

// File: rtl/biu_in_filter.sv
// SDA input path: synchronizer, glitch filter and START/STOP edge detection.
module biu_in_filter
  import biu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sda_pin,
  input  logic scl,
  output logic isda,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_CNT_W-1:0]  cnt_q;
  logic                   isda_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      isda      <= SDA_IDLE;
      isda_d    <= SDA_IDLE;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sda_pin};

      // The count reaching FILTER_LEN on this cycle commits the new level.
      if (sample != isda) begin
        if (cnt_q == FILT_CNT_W'(FILTER_LEN - 1)) begin
          isda  <= sample;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end

      isda_d    <= isda;
      start_det <= isda_d & ~isda & scl;
      stop_det  <= ~isda_d & isda & scl;
    end
  end

endmodule

// File: rtl/biu.sv
// I2C bus interface unit: registered SCL/SDA drive, filtered SDA return,
// START/STOP pulses and sticky arbitration-loss flag.
module biu
  import biu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic iSCL,
  input  logic oSDA,
  input  logic en,
  output logic SCL,
  output logic iSDA,
  inout  wire  SDA,
  output logic start_det,
  output logic stop_det,
  output logic arb_lost
);

  logic scl_q;
  logic sda_q;
  logic en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= SCL_IDLE;
      sda_q <= SDA_IDLE;
      en_q  <= 1'b0;
    end else begin
      scl_q <= iSCL;
      sda_q <= oSDA;
      en_q  <= en;
    end
  end

  assign SCL = scl_q;
  assign SDA = en_q ? sda_q : 1'bz;

  biu_in_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_in_filter (
    .clk       (clk),
    .rst       (rst),
    .sda_pin   (SDA),
    .scl       (scl_q),
    .isda      (iSDA),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Setting wins over the en-driven clear when both occur together.
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_lost <= 1'b0;
    end else if (en_q && sda_q && scl_q && !iSDA) begin
      arb_lost <= 1'b1;
    end else if (!en) begin
      arb_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_biu.sv
// Scoreboard bench for biu: stimulus pushes expected per-cycle responses
// from a behavioural bus model; a negedge monitor pops and compares.
module tb_biu;
  localparam int unsigned SYNC = 2;
  localparam int unsigned FLEN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iSCL = 1'b1;
  logic oSDA = 1'b1;
  logic en = 1'b0;
  logic SCL, iSDA, start_det, stop_det, arb_lost;
  wire  SDA;

  // Bench side of the bus: drives whenever the modelled BIU has released SDA,
  // standing in for the pull-up (value 1) or another device (value 0).
  logic tb_drv = 1'b1;
  logic tb_val = 1'b1;
  assign SDA = tb_drv ? tb_val : 1'bz;

  biu #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .iSCL      (iSCL),
    .oSDA      (oSDA),
    .en        (en),
    .SCL       (SCL),
    .iSDA      (iSDA),
    .SDA       (SDA),
    .start_det (start_det),
    .stop_det  (stop_det),
    .arb_lost  (arb_lost)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tag;
    bit scl, isda, st, sp, arb, drv, sda;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Behavioural model of the bus interface.
  bit m_scl, m_sda, m_en;
  bit m_pipe[$];
  int m_run;
  bit m_isda, m_prev_isda, m_start, m_stop, m_arb;

  function automatic void m_reset();
    m_scl = 1; m_sda = 1; m_en = 0;
    m_pipe = {};
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b1);
    m_run = 0;
    m_isda = 1; m_prev_isda = 1;
    m_start = 0; m_stop = 0; m_arb = 0;
  endfunction

  function automatic void m_step(bit r, bit sc, bit os, bit e, bit tv);
    bit line, seen, nisda;
    if (r) begin
      m_reset();
      return;
    end
    line = m_en ? m_sda : tv;
    seen = m_pipe.pop_front();
    m_pipe.push_back(line);

    m_start = m_prev_isda && !m_isda && m_scl;
    m_stop  = !m_prev_isda && m_isda && m_scl;
    if (m_en && m_sda && m_scl && !m_isda) m_arb = 1;
    else if (!e) m_arb = 0;

    nisda = m_isda;
    if (seen == m_isda) m_run = 0;
    else begin
      m_run = m_run + 1;
      if (m_run == FLEN) begin
        nisda = seen;
        m_run = 0;
      end
    end
    m_prev_isda = m_isda;
    m_isda = nisda;
    m_scl = sc; m_sda = os; m_en = e;
  endfunction

  task automatic drive(input bit r, input bit sc, input bit os, input bit e, input bit tv);
    exp_t x;
    rst = r; iSCL = sc; oSDA = os; en = e; tb_val = tv;
    m_step(r, sc, os, e, tv);
    x.tag = cyc + 1;
    x.scl = m_scl; x.isda = m_isda; x.st = m_start; x.sp = m_stop;
    x.arb = m_arb; x.drv = m_en; x.sda = m_sda;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    tb_drv = !m_en;
  endtask

  task automatic chk(input string name, input logic got, input bit want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b exp=%b", name, cyc, got, want);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
        x = exp_q.pop_front();
        chk("SCL", SCL, x.scl);
        chk("iSDA", iSDA, x.isda);
        chk("start_det", start_det, x.st);
        chk("stop_det", stop_det, x.sp);
        chk("arb_lost", arb_lost, x.arb);
        if (x.drv) chk("SDA_drive", SDA, x.sda);
      end
    end
  end

  initial begin
    m_reset();
    // Reset with a pending drive request: SDA must stay released.
    repeat (2) drive(1, 1, 0, 1, 1);
    // Drive high, then release and let the bench pull low and back.
    repeat (8) drive(0, 1, 1, 1, 1);
    repeat (8) drive(0, 1, 0, 0, 0);
    repeat (8) drive(0, 1, 0, 0, 1);
    // SCL toggling every 5 clocks.
    for (int k = 0; k < 40; k++) drive(0, ((k / 5) % 2) == 0, 1, 0, 1);
    // Glitch shorter than the filter, then a genuine low with SCL high.
    repeat (2) drive(0, 1, 1, 0, 0);
    repeat (8) drive(0, 1, 1, 0, 1);
    repeat (5) drive(0, 1, 1, 0, 0);
    repeat (8) drive(0, 1, 1, 0, 1);
    // SDA activity with SCL low must not pulse.
    for (int k = 0; k < 24; k++) drive(0, 0, 1, 0, (k / 6) % 2 == 0);
    // Drive low, then release high while filtered SDA still reads low.
    repeat (8) drive(0, 1, 0, 1, 1);
    repeat (10) drive(0, 1, 1, 1, 1);
    repeat (4) drive(0, 1, 1, 0, 1);
    // Randomized segments, including occasional mid-transfer resets.
    for (int s = 0; s < 120; s++) begin
      int unsigned len;
      bit sc, os, e, tv;
      len = $urandom_range(1, 8);
      sc = 1'($urandom);
      os = 1'($urandom);
      e  = ($urandom_range(0, 2) == 0);
      tv = 1'($urandom);
      if ($urandom_range(0, 29) == 0) drive(1, sc, os, e, tv);
      for (int k = 0; k < len; k++) drive(0, sc, os, e, tv);
    end
    repeat (10) drive(0, 1, 1, 0, 1);
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
